hasti_timem_bridge: RTL and testbench



---
 rtl/hasti_timem_bridge_if.sv | 25 ++
 rtl/hasti_timem_bridge.sv | 48 ++++
 tb/tb_hasti_timem_bridge.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hasti_timem_bridge_if.sv
// hasti_timem_bridge_if: HASTI slave bus plus single-port memory side of the bridge.
interface hasti_timem_bridge_if;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  haddr, hwrite, hsize, htrans, hwdata, mem_rdata,
    output hrdata, hready, hresp, mem_addr, mem_read, mem_write, mem_size, mem_wdata
  );
  modport master (
    output haddr, hwrite, hsize, htrans, hwdata, mem_rdata,
    input  hrdata, hready, hresp, mem_addr, mem_read, mem_write, mem_size, mem_wdata
  );
endinterface

// File: rtl/hasti_timem_bridge.sv
// hasti_timem_bridge: HASTI slave to single-port TIMEM, with write registering, write->read stall and ERROR responses.
module hasti_timem_bridge #(
  parameter int MEM_ADDR_BITS = 14
) (
  input logic hclk,
  input logic hresetn,
  hasti_timem_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, ERR1, ERR2} state_t;
  state_t      state_q;
  logic [31:0] wr_addr_q;
  logic [2:0]  wr_size_q;
  logic        act, bad, rd_req, rdy;
  logic [31:0] sel_addr;
  always_comb begin
    act = bus.htrans inside {2'd2, 2'd3};
    bad = bus.hsize > 3'd2 || (bus.hsize == 3'd1 && bus.haddr[0]) || (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00);
    rd_req = act && !bus.hwrite && !bad;
    // a pending write owns the port, so a read arriving in its data phase is stalled
    rdy = state_q == ERR1 ? 1'b0 : state_q == WR ? !rd_req : 1'b1;
    sel_addr = state_q == WR ? wr_addr_q : bus.haddr;
    bus.hready = rdy || !hresetn;
    bus.hresp = hresetn && (state_q == ERR1 || state_q == ERR2);
    bus.hrdata = (hresetn && state_q == RD) ? bus.mem_rdata : '0;
    bus.mem_write = hresetn && state_q == WR;
    bus.mem_read = hresetn && rdy && rd_req;
    bus.mem_addr = {sel_addr[31:MEM_ADDR_BITS], sel_addr[MEM_ADDR_BITS-1:0]};
    bus.mem_size = state_q == WR ? wr_size_q : bus.hsize;
    bus.mem_wdata = bus.hwdata;
  end
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= IDLE;
      wr_addr_q <= '0;
      wr_size_q <= '0;
    end else if (state_q == ERR1) begin
      state_q <= ERR2;
    end else if (rdy && act) begin
      state_q <= bad ? ERR1 : bus.hwrite ? WR : RD;
      if (!bad && bus.hwrite) begin
        wr_addr_q <= bus.haddr;
        wr_size_q <= bus.hsize;
      end
    end else begin
      state_q <= state_q == WR ? WR_HOLD : IDLE;
    end
  end
endmodule

// File: tb/tb_hasti_timem_bridge.sv
// tb_hasti_timem_bridge: randomized HASTI traffic against a byte-array reference model, checked by a scoreboard monitor.
module tb_hasti_timem_bridge;
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;
  hasti_timem_bridge_if bus ();
  hasti_timem_bridge dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));

  typedef struct {
    logic [1:0]  tr;
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } tx_t;
  typedef struct {
    bit          rd;
    bit          err;
    int          waits;
    logic [31:0] data;
  } exp_t;

  tx_t         tx[$];
  exp_t        sb[$];
  logic [7:0]  mdl[0:16383];
  logic [31:0] ram[0:4095];
  int vecs = 0, errs = 0;
  int exp_wr = 0, exp_rd = 0, hw_wr = 0, hw_rd = 0;
  bit run = 0, both_seen = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, got, want);
    end
  endtask

  function automatic bit is_act(input tx_t t);
    return t.tr == 2'd2 || t.tr == 2'd3;
  endfunction
  function automatic bit is_bad(input tx_t t);
    return t.sz > 3'd2 || (t.a % (32'd1 << t.sz)) != 0;
  endfunction

  always @(posedge hclk) begin
    if (bus.mem_write)
      for (int b = 0; b < 4; b++)
        if (b >= int'(bus.mem_addr[1:0]) && b < int'(bus.mem_addr[1:0]) + (1 << bus.mem_size))
          ram[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    if (bus.mem_read) bus.mem_rdata <= ram[bus.mem_addr[13:2]];
  end

  always @(negedge hclk) begin
    hw_wr += int'(bus.mem_write);
    hw_rd += int'(bus.mem_read);
    if (bus.mem_read && bus.mem_write) both_seen = 1;
  end

  bit dp = 0;
  int w = 0;
  always @(negedge hclk) begin
    exp_t e;
    if (!run || !hresetn) begin
      dp = 0;
      w = 0;
    end else begin
      if (dp) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
          dp = 0;
        end else if (!bus.hready) begin
          w++;
          chk("hresp_wait", 32'(bus.hresp), 32'(sb[0].err));
          if (w > 4) begin
            chk("wait_bound", 32'(w), 32'(sb[0].waits));
            void'(sb.pop_front());
            dp = 0;
            w = 0;
          end
        end else begin
          e = sb.pop_front();
          chk("waits", 32'(w), 32'(e.waits));
          chk("hresp", 32'(bus.hresp), 32'(e.err));
          if (e.rd && !e.err) chk("hrdata", bus.hrdata, e.data);
          w = 0;
          dp = 0;
        end
      end
      if (bus.hready && (bus.htrans == 2'd2 || bus.htrans == 2'd3)) dp = 1;
    end
  end

  task automatic present(input tx_t t);
    bus.htrans = t.tr;
    bus.hwrite = t.wr;
    bus.hsize = t.sz;
    bus.haddr = t.a;
  endtask

  task automatic add(input logic [1:0] tr, input bit wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    tx_t t;
    t.tr = tr; t.wr = wr; t.sz = sz; t.a = a; t.d = d;
    tx.push_back(t);
  endtask

  task automatic accept(input int i, output logic [31:0] wd);
    tx_t  t;
    exp_t e;
    logic [31:0] a4;
    t = tx[i];
    e.rd = !t.wr;
    e.err = is_bad(t);
    e.data = '0;
    e.waits = e.err ? 1 : (t.wr && is_act(tx[i+1]) && !tx[i+1].wr && !is_bad(tx[i+1])) ? 1 : 0;
    wd = t.wr ? t.d : $urandom;
    if (!e.err) begin
      if (t.wr) begin
        exp_wr++;
        for (int b = 0; b < (1 << t.sz); b++)
          mdl[t.a + b] = t.d[8*((t.a + b) % 4) +: 8];
      end else begin
        exp_rd++;
        a4 = t.a & ~32'd3;
        e.data = {mdl[a4+3], mdl[a4+2], mdl[a4+1], mdl[a4]};
      end
    end
    sb.push_back(e);
  endtask

  initial begin
    tx_t t;
    int idx, cyc, n;
    bit rdy;
    logic [31:0] wd;
    for (int i = 0; i < 16384; i++) mdl[i] = '0;
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    bus.mem_rdata = '0;
    bus.hwdata = '0;
    add(2'd2, 1'b0, 3'd2, 32'h100, 32'h0);
    present(tx[0]);
    tx.delete();
    repeat (2) begin
      @(negedge hclk);
      chk("rst_hready", 32'(bus.hready), 32'd1);
      chk("rst_hresp", 32'(bus.hresp), 32'd0);
      chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
      chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    end
    @(posedge hclk);
    #1 hresetn = 1'b1;
    bus.htrans = 2'd0;
    @(negedge hclk);
    chk("post_rst_hready", 32'(bus.hready), 32'd1);
    chk("post_rst_hrdata", bus.hrdata, 32'd0);
    chk("post_rst_hresp", 32'(bus.hresp), 32'd0);

    add(2'd2, 1, 3'd2, 32'h100, 32'hDEADBEEF);
    add(2'd0, 0, 3'd0, 32'h0, 32'h0);
    add(2'd2, 0, 3'd2, 32'h100, 32'h0);
    add(2'd2, 1, 3'd2, 32'h200, 32'h11223344);
    add(2'd2, 0, 3'd2, 32'h200, 32'h0);
    add(2'd2, 1, 3'd0, 32'h203, 32'hAB000000);
    add(2'd2, 0, 3'd2, 32'h200, 32'h0);
    add(2'd2, 0, 3'd2, 32'h102, 32'h0);
    add(2'd2, 0, 3'd2, 32'h100, 32'h0);
    add(2'd0, 0, 3'd0, 32'h0, 32'h0);
    repeat (300) begin
      n = $urandom_range(0, 19);
      t.tr = n < 3 ? 2'd0 : n == 3 ? 2'd1 : 2'($urandom_range(2, 3));
      t.wr = 1'($urandom);
      n = $urandom_range(0, 9);
      t.sz = n == 9 ? 3'($urandom_range(3, 7)) : 3'(n % 3);
      t.a = 32'($urandom_range(0, 63));
      t.d = $urandom;
      tx.push_back(t);
    end
    n = tx.size();
    repeat (4) add(2'd0, 0, 3'd0, 32'h0, 32'h0);

    @(posedge hclk);
    #1 run = 1;
    idx = 0;
    cyc = 0;
    present(tx[0]);
    while (idx < n) begin
      @(negedge hclk);
      rdy = bus.hready;
      @(posedge hclk);
      wd = bus.hwdata;
      if (rdy) begin
        if (is_act(tx[idx])) accept(idx, wd);
        else wd = $urandom;
        idx++;
      end
      #1 bus.hwdata = wd;
      present(tx[idx]);
      if (++cyc > 20 * n) begin
        chk("stream_timeout", 32'(idx), 32'(n));
        break;
      end
    end
    repeat (4) @(posedge hclk);
    #1 run = 0;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    t.tr = 2'd2; t.wr = 1; t.sz = 3'd2; t.a = 32'h300; t.d = 32'hCAFEF00D;
    present(t);
    @(negedge hclk);
    chk("hold_wr_accept", 32'(bus.hready), 32'd1);
    @(posedge hclk);
    #1 bus.hwdata = t.d;
    t.wr = 0;
    present(t);
    exp_wr++;
    @(negedge hclk);
    chk("hold_stall", 32'(bus.hready), 32'd0);
    chk("hold_write", 32'(bus.mem_write), 32'd1);
    chk("hold_no_read", 32'(bus.mem_read), 32'd0);
    @(posedge hclk);
    #1 hresetn = 1'b0;
    @(negedge hclk);
    chk("hold_rst_write", 32'(bus.mem_write), 32'd0);
    chk("hold_rst_read", 32'(bus.mem_read), 32'd0);
    chk("hold_rst_hready", 32'(bus.hready), 32'd1);
    @(posedge hclk);
    #1 hresetn = 1'b1;
    bus.htrans = 2'd0;
    @(negedge hclk);
    chk("hold_idle_hready", 32'(bus.hready), 32'd1);
    chk("hold_idle_hrdata", bus.hrdata, 32'd0);
    chk("hold_idle_write", 32'(bus.mem_write), 32'd0);
    chk("hold_ram", ram[32'h300 >> 2], 32'hCAFEF00D);
    @(posedge hclk);
    chk("write_count", 32'(hw_wr), 32'(exp_wr));
    chk("read_count", 32'(hw_rd), 32'(exp_rd));
    chk("strobe_exclusive", 32'(both_seen), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
